// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - Request/write-back bundle between the core and the multiply/divide unit
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            we;

    modport master (
        output start, funct3, a, b, rd_in,
        input  busy, done, result, rd_out, we
    );

    modport slave (
        input  start, funct3, a, b, rd_in,
        output busy, done, result, rd_out, we
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - Iterative RV32M multiply/divide unit; MULDIV_EARLY_OUT_EN enables 1-cycle trivial cases
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_main_q, neg_main_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div0_q, div0_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic              in_signed_a, in_signed_b;
    logic [XLEN-1:0]   in_mag_a, in_mag_b;

    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     sub_shift;
    logic [XLEN+1:0]   sub_diff;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        in_signed_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        in_signed_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
        in_mag_a    = (in_signed_a && bus.a[XLEN-1]) ? -bus.a : bus.a;
        in_mag_b    = (in_signed_b && bus.b[XLEN-1]) ? -bus.b : bus.b;
    end

    // acc holds {hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        sub_shift = acc_q[2*XLEN-1:XLEN-1];
        sub_diff  = {1'b0, sub_shift} - {2'b00, mag_b_q};
        if (op_q[2]) begin
            if (sub_diff[XLEN+1]) begin
                acc_step = {sub_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
                acc_step = {sub_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_step = {add_sum, acc_q[XLEN-1:1]};
        end
    end

    function automatic logic [XLEN-1:0] select_result(
        input logic [2:0]        op,
        input logic [2*XLEN-1:0] acc,
        input logic              neg_main,
        input logic              neg_rem,
        input logic              div0
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = neg_main ? -acc : acc;
        quo  = div0 ? '1 : (neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
        // With a zero divisor the remainder register ends up holding |a|, so sign fixup yields a
        rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            3'b000:                 select_result = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: select_result = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         select_result = quo;
            default:                select_result = rem;
        endcase
    endfunction

`ifdef MULDIV_EARLY_OUT_EN
    logic            early_out;
    logic [XLEN-1:0] early_res;

    always_comb begin
        early_out = 1'b0;
        early_res = '0;
        if (bus.funct3[2]) begin
            if (bus.b == '0) begin
                early_out = 1'b1;
                early_res = bus.funct3[1] ? bus.a : '1;
            end else if (!bus.funct3[0] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1)) begin
                early_out = 1'b1;
                early_res = bus.funct3[1] ? '0 : bus.a;
            end
        end else if ((bus.a == '0) || (bus.b == '0)) begin
            early_out = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        mag_b_d    = mag_b_q;
        acc_d      = acc_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        div0_d     = div0_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        rd_out_d   = rd_out_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d       = bus.funct3;
                    rd_d       = bus.rd_in;
                    acc_d      = {{XLEN{1'b0}}, in_mag_a};
                    mag_b_d    = in_mag_b;
                    neg_main_d = (in_signed_a & bus.a[XLEN-1]) ^ (in_signed_b & bus.b[XLEN-1]);
                    neg_rem_d  = in_signed_a & bus.a[XLEN-1];
                    div0_d     = (bus.b == '0);
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early_out) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = early_res;
                        rd_out_d = bus.rd_in;
                    end
`endif
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(XLEN-1)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = select_result(op_q, acc_step, neg_main_q, neg_rem_q, div0_q);
                    rd_out_d = rd_q;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            mag_b_q    <= '0;
            acc_q      <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            rd_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            mag_b_q    <= mag_b_d;
            acc_q      <= acc_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            div0_q     <= div0_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            rd_out_q   <= rd_out_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
    assign bus.we     = done_q & (rd_out_q != 5'd0);
endmodule
